// File: rtl/mmio_responder.sv
// mmio_responder: 16-word MMIO window (LED, HEX, KEY, KEYEDGE, timer) beside bram16.
// Optional macro MMIO_KEY_SYNC_EN adds a 2-flop synchronizer in front of the KEY logic.
module mmio_responder #(
    parameter int                    ADDR_WIDTH = 9,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 9'h1F0,
    parameter logic [15:0]           TMR_RESET  = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           din,
    output logic [15:0]           dout,
    output logic                  hit_q,
    input  logic [3:0]            key_n,
    output logic [9:0]            ledr,
    output logic [15:0]           hex_val,
    output logic                  timer_irq
);

    localparam logic [3:0] OFF_LED    = 4'd0;
    localparam logic [3:0] OFF_HEX    = 4'd1;
    localparam logic [3:0] OFF_KEY    = 4'd2;
    localparam logic [3:0] OFF_KEDGE  = 4'd3;
    localparam logic [3:0] OFF_COUNT  = 4'd4;
    localparam logic [3:0] OFF_CTRL   = 4'd5;
    localparam logic [3:0] OFF_PERIOD = 4'd6;

    logic        hit;
    logic        rd;
    logic        wr;
    logic [3:0]  off;
    logic [15:0] rdata;
    logic [3:0]  key_cur;
    logic [3:0]  key_press;
    logic        tick;

    logic [15:0] dout_q, dout_d;
    logic        hit_q_q, hit_q_d;
    logic [9:0]  led_q, led_d;
    logic [15:0] hex_q, hex_d;
    logic [3:0]  kedge_q, kedge_d;
    logic [15:0] count_q, count_d;
    logic [15:0] period_q, period_d;
    logic        tmr_en_q, tmr_en_d;
    logic        wrap_q, wrap_d;
    logic [3:0]  key_prev_q, key_prev_d;

`ifdef MMIO_KEY_SYNC_EN
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    // Two-stage synchronizer; the second stage feeds the KEY logic
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        key_cur = sync2_q;
    end

    // Synchronizer flops reset to released (all high)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
`else
    // Raw key inputs feed the KEY logic directly
    always_comb begin
        key_cur = key_n;
    end
`endif

    // Address decode and press detection (high-to-low on key_n)
    always_comb begin
        hit       = en & (addr[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]);
        off       = addr[3:0];
        rd        = hit & ~we;
        wr        = hit & we;
        key_press = key_prev_q & ~key_cur;
        tick      = tmr_en_q & (count_q == period_q);
    end

    // Read mux over current register values
    always_comb begin
        rdata = 16'h0000;
        case (off)
            OFF_LED:    rdata = {6'd0, led_q};
            OFF_HEX:    rdata = hex_q;
            OFF_KEY:    rdata = {12'd0, ~key_cur};
            OFF_KEDGE:  rdata = {12'd0, kedge_q};
            OFF_COUNT:  rdata = count_q;
            OFF_CTRL:   rdata = {14'd0, wrap_q, tmr_en_q};
            OFF_PERIOD: rdata = period_q;
            default:    rdata = 16'h0000;
        endcase
    end

    // Next-state logic: register writes, W1C flags, timer and read response
    always_comb begin
        led_d      = led_q;
        hex_d      = hex_q;
        period_d   = period_q;
        tmr_en_d   = tmr_en_q;
        key_prev_d = key_cur;
        kedge_d    = kedge_q;
        wrap_d     = wrap_q;
        count_d    = count_q;

        if (wr) begin
            case (off)
                OFF_LED:    led_d    = din[9:0];
                OFF_HEX:    hex_d    = din;
                OFF_PERIOD: period_d = din;
                OFF_CTRL:   tmr_en_d = din[0];
                default:    ;
            endcase
        end

        // A new press survives a simultaneous clear of the same bit
        if (wr && off == OFF_KEDGE) begin
            kedge_d = kedge_q & ~din[3:0];
        end
        kedge_d = kedge_d | key_press;

        // A wrap in the same cycle survives a W1C clear
        if (wr && off == OFF_CTRL && din[1]) begin
            wrap_d = 1'b0;
        end
        wrap_d = wrap_d | tick;

        // A software load of COUNT takes precedence over counting
        if (wr && off == OFF_COUNT) begin
            count_d = din;
        end else if (tmr_en_q) begin
            count_d = tick ? 16'h0000 : count_q + 16'd1;
        end

        hit_q_d = rd;
        dout_d  = rd ? rdata : dout_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= 16'h0000;
            hit_q_q    <= 1'b0;
            led_q      <= 10'h000;
            hex_q      <= 16'h0000;
            kedge_q    <= 4'h0;
            count_q    <= 16'h0000;
            period_q   <= TMR_RESET;
            tmr_en_q   <= 1'b0;
            wrap_q     <= 1'b0;
            key_prev_q <= 4'hF;
        end else begin
            dout_q     <= dout_d;
            hit_q_q    <= hit_q_d;
            led_q      <= led_d;
            hex_q      <= hex_d;
            kedge_q    <= kedge_d;
            count_q    <= count_d;
            period_q   <= period_d;
            tmr_en_q   <= tmr_en_d;
            wrap_q     <= wrap_d;
            key_prev_q <= key_prev_d;
        end
    end

    // Output mapping
    always_comb begin
        dout      = dout_q;
        hit_q     = hit_q_q;
        ledr      = led_q;
        hex_val   = hex_q;
        timer_irq = wrap_q;
    end

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed steps then random traffic vs. a register-map model.
// Honours MMIO_KEY_SYNC_EN for key latency.
module tb_mmio_responder;

`ifdef MMIO_KEY_SYNC_EN
    localparam int KD = 2;
`else
    localparam int KD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [8:0]  addr = 9'h000;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic        hit_q;
    logic [3:0]  key_n = 4'hF;
    logic [9:0]  ledr;
    logic [15:0] hex_val;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    logic [3:0] kcur = 4'hF;

    // Model of the register map
    logic [9:0]  m_led = '0;
    logic [15:0] m_hex = '0;
    logic [3:0]  m_kedge = '0;
    logic [15:0] m_count = '0;
    logic [15:0] m_period = 16'hFFFF;
    logic        m_en = 1'b0;
    logic        m_wrap = 1'b0;
    logic [15:0] m_dout = '0;
    logic        m_hitq = 1'b0;
    logic [3:0]  khist [3] = '{4'hF, 4'hF, 4'hF};

    mmio_responder dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .we(we),
        .addr(addr),
        .din(din),
        .dout(dout),
        .hit_q(hit_q),
        .key_n(key_n),
        .ledr(ledr),
        .hex_val(hex_val),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic w,
                         input logic [8:0] a, input logic [15:0] d,
                         input logic [3:0] k);
        logic [3:0]  eff_now;
        logic [3:0]  eff_prev;
        logic        hit;
        logic        wr;
        logic        tick;
        logic [3:0]  off;
        logic [15:0] rv;
        rst   = r;
        en    = e;
        we    = w;
        addr  = a;
        din   = d;
        key_n = k;
        eff_now  = (KD == 0) ? k : khist[1];
        eff_prev = (KD == 0) ? khist[0] : khist[2];
        hit = e && (a[8:4] == 5'h1F);
        wr  = hit && w;
        off = a[3:0];
        case (off)
            4'd0:    rv = {6'd0, m_led};
            4'd1:    rv = m_hex;
            4'd2:    rv = {12'd0, ~eff_now};
            4'd3:    rv = {12'd0, m_kedge};
            4'd4:    rv = m_count;
            4'd5:    rv = {14'd0, m_wrap, m_en};
            4'd6:    rv = m_period;
            default: rv = 16'h0000;
        endcase
        tick = m_en && (m_count == m_period);
        if (r) begin
            m_led = '0; m_hex = '0; m_kedge = '0; m_count = '0;
            m_period = 16'hFFFF; m_en = 1'b0; m_wrap = 1'b0;
            m_dout = '0; m_hitq = 1'b0;
            khist = '{4'hF, 4'hF, 4'hF};
        end else begin
            if (wr && off == 4'd4) m_count = d;
            else if (m_en) m_count = tick ? 16'h0000 : m_count + 16'd1;
            if (wr && off == 4'd5 && d[1]) m_wrap = 1'b0;
            if (tick) m_wrap = 1'b1;
            if (wr && off == 4'd3) m_kedge = m_kedge & ~d[3:0];
            m_kedge = m_kedge | (eff_prev & ~eff_now);
            if (wr && off == 4'd0) m_led = d[9:0];
            if (wr && off == 4'd1) m_hex = d;
            if (wr && off == 4'd5) m_en = d[0];
            if (wr && off == 4'd6) m_period = d;
            m_hitq = hit && !w;
            if (m_hitq) m_dout = rv;
            khist[2] = khist[1];
            khist[1] = khist[0];
            khist[0] = k;
        end
        @(posedge clk);
        #1;
        chk("hit_q", {15'd0, hit_q}, {15'd0, m_hitq});
        chk("dout", dout, m_dout);
        chk("ledr", {6'd0, ledr}, {6'd0, m_led});
        chk("hex_val", hex_val, m_hex);
        chk("timer_irq", {15'd0, timer_irq}, {15'd0, m_wrap});
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, kcur);
    endtask

    task automatic wrr(input logic [3:0] o, input logic [15:0] d);
        cycle(1'b0, 1'b1, 1'b1, {5'h1F, o}, d, kcur);
    endtask

    task automatic rdr(input logic [3:0] o);
        cycle(1'b0, 1'b1, 1'b0, {5'h1F, o}, 16'h0000, kcur);
    endtask

    initial begin
        logic [15:0] exp_cnt [5];
        logic [15:0] exp_ld  [4];
        logic [8:0]  ra;
        exp_cnt = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
        exp_ld  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        cycle(1'b1, 1'b0, 1'b0, 9'h000, 16'h0000, kcur);
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 16'h0000, kcur);
        chk("reset_dout", dout, 16'h0000);
        chk("reset_hit", {15'd0, hit_q}, 16'h0000);
        rdr(4'd6);
        chk("reset_period", dout, 16'hFFFF);

        // LED write/read
        wrr(4'd0, 16'h03FF);
        chk("led_write", {6'd0, ledr}, 16'h03FF);
        rdr(4'd0);
        chk("led_read_hit", {15'd0, hit_q}, 16'h0001);
        chk("led_read", dout, 16'h03FF);

        // HEX write, then non-MMIO read
        wrr(4'd1, 16'hBEEF);
        cycle(1'b0, 1'b1, 1'b0, 9'h0F1, 16'h0000, kcur);
        chk("nonhit_hit", {15'd0, hit_q}, 16'h0000);
        chk("nonhit_hex", hex_val, 16'hBEEF);
        chk("nonhit_dout", dout, 16'h03FF);

        // KEYEDGE press and W1C vs new press
        kcur = 4'hD;
        idle(); idle(); idle();
        rdr(4'd3);
        chk("kedge_press", dout, 16'h0002);
        kcur = 4'h9;
        wrr(4'd3, 16'h0002);
        idle(); idle(); idle();
        rdr(4'd3);
        chk("kedge_w1c_race", dout, 16'h0004);
        rdr(4'd2);
        chk("key_level", dout, 16'h0006);
        kcur = 4'hF;
        idle(); idle(); idle();

        // Timer PERIOD=3
        wrr(4'd6, 16'd3);
        wrr(4'd4, 16'd0);
        wrr(4'd5, 16'd1);
        for (int i = 0; i < 5; i++) begin
            rdr(4'd4);
            chk("count_seq", dout, exp_cnt[i]);
        end
        chk("wrap_set", {15'd0, timer_irq}, 16'h0001);
        wrr(4'd5, 16'd3);
        chk("wrap_clear", {15'd0, timer_irq}, 16'h0000);
        idle();
        wrr(4'd5, 16'd3);
        chk("wrap_beats_w1c", {15'd0, timer_irq}, 16'h0001);

        // PERIOD=0: wrap every cycle
        wrr(4'd5, 16'd2);
        wrr(4'd6, 16'd0);
        wrr(4'd4, 16'd0);
        wrr(4'd5, 16'd1);
        idle();
        chk("p0_wrap", {15'd0, timer_irq}, 16'h0001);
        for (int i = 0; i < 2; i++) begin
            rdr(4'd4);
            chk("p0_count", dout, 16'h0000);
        end

        // COUNT loaded above PERIOD wraps silently
        wrr(4'd5, 16'd2);
        wrr(4'd5, 16'd2);
        chk("p0_cleared", {15'd0, timer_irq}, 16'h0000);
        wrr(4'd6, 16'd5);
        wrr(4'd4, 16'hFFFE);
        wrr(4'd5, 16'd1);
        for (int i = 0; i < 4; i++) begin
            rdr(4'd4);
            chk("ovf_count", dout, exp_ld[i]);
            chk("ovf_nowrap", {15'd0, timer_irq}, 16'h0000);
        end
        idle(); idle(); idle();
        chk("ovf_prewrap", {15'd0, timer_irq}, 16'h0000);
        idle();
        chk("ovf_wrap", {15'd0, timer_irq}, 16'h0001);

        // Reset during an in-flight read
        wrr(4'd1, 16'h1234);
        rdr(4'd1);
        cycle(1'b1, 1'b0, 1'b0, 9'h000, 16'h0000, kcur);
        chk("rst_dout", dout, 16'h0000);
        chk("rst_hit", {15'd0, hit_q}, 16'h0000);
        chk("rst_hex", hex_val, 16'h0000);
        chk("rst_irq", {15'd0, timer_irq}, 16'h0000);
        rdr(4'd6);
        chk("rst_period", dout, 16'hFFFF);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) != 0) ra = {5'h1F, 4'($urandom_range(15))};
            else ra = 9'($urandom);
            if ($urandom_range(7) == 0) kcur = 4'($urandom);
            if ($urandom_range(3) == 0) begin
                cycle(1'b0, 1'b1, 1'b1, {5'h1F, 4'd6}, 16'($urandom_range(20)), kcur);
            end else begin
                cycle($urandom_range(99) == 0, 1'($urandom), 1'($urandom),
                      ra, 16'($urandom), kcur);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
